// File: rtl/seq_fetch_unit.sv
// seq_fetch_unit: Y86-64 byte-serial fetch stage; define FETCH_IFUN_CHECK_EN to also flag illegal ifun codes
module seq_fetch_unit #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [63:0] PC,
  input  logic        start,
  output logic [63:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        busy,
  output logic        instr_valid,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic        instr_invalid,
  output logic        imem_error
);
  typedef enum logic [2:0] {IDLE, BYTE0, REGS, CONST, DONE} state_t;
  state_t state, state_n;
  logic [63:0] base, addr;
  logic [3:0] len, blen, bic, bfn;
  logic [2:0] k;
  logic [7:0] wcnt;
  logic hc, take, tout, bregs, bconst, bbad;
  assign mem_rd = state == BYTE0 || state == REGS || state == CONST;
  assign busy = mem_rd;
  assign instr_valid = state == DONE;
  assign mem_addr = addr;
  assign valP = base + {60'd0, len};
  assign take = mem_rd & mem_ack;
  assign tout = mem_rd & ~mem_ack & (wcnt == 8'(ACK_TIMEOUT - 1));
  assign bic = mem_rdata[7:4];
  assign bfn = mem_rdata[3:0];
  // Decode byte 0 into instruction length, trailing fields and legality
  always_comb begin
    blen = 4'd1;
    case (bic)
      4'h2, 4'h6, 4'hA, 4'hB: blen = 4'd2;
      4'h3, 4'h4, 4'h5:       blen = 4'd10;
      4'h7, 4'h8:             blen = 4'd9;
      default:                blen = 4'd1;
    endcase
    bregs = blen == 4'd2 || blen == 4'd10;
    bconst = blen > 4'd8;
`ifdef FETCH_IFUN_CHECK_EN
    bbad = bic > 4'hB || (bic == 4'h2 || bic == 4'h7 ? bfn > 4'h6 : bic == 4'h6 ? bfn > 4'h3 : bfn != 4'h0);
`else
    bbad = bic > 4'hB;
`endif
  end
  // Next-state: advance on each consumed byte, bail to DONE on ack timeout
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? BYTE0 : IDLE;
      BYTE0:   state_n = tout ? DONE : !take ? BYTE0 : bregs ? REGS : bconst ? CONST : DONE;
      REGS:    state_n = tout ? DONE : !take ? REGS : hc ? CONST : DONE;
      CONST:   state_n = tout || (take && k == 3'd7) ? DONE : CONST;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // State register
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else state <= state_n;
  end
  // Fetch address, wait counter and instruction fields
  always_ff @(posedge Clk) begin
    if (Reset) begin
      base <= '0;
      addr <= '0;
      len <= '0;
      k <= '0;
      wcnt <= '0;
      hc <= 1'b0;
      icode <= '0;
      ifun <= '0;
      rA <= 4'hF;
      rB <= 4'hF;
      valC <= '0;
      instr_invalid <= 1'b0;
      imem_error <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        base <= PC;
        addr <= PC;
        len <= 4'd1;
        k <= '0;
        wcnt <= '0;
        hc <= 1'b0;
        icode <= '0;
        ifun <= '0;
        rA <= 4'hF;
        rB <= 4'hF;
        valC <= '0;
        instr_invalid <= 1'b0;
        imem_error <= 1'b0;
      end
      if (take) begin
        addr <= addr + 64'd1;
        wcnt <= '0;
      end else if (mem_rd) wcnt <= wcnt + 8'd1;
      if (tout) imem_error <= 1'b1;
      if (take && state == BYTE0) begin
        icode <= bic;
        ifun <= bfn;
        len <= blen;
        hc <= bconst;
        instr_invalid <= bbad;
      end
      if (take && state == REGS) begin
        rA <= mem_rdata[7:4];
        rB <= mem_rdata[3:0];
      end
      if (take && state == CONST) begin
        valC[{k, 3'b000} +: 8] <= mem_rdata;
        k <= k + 3'd1;
      end
    end
  end
endmodule

// File: tb/tb_seq_fetch_unit.sv
// tb_seq_fetch_unit: directed scoreboard bench for seq_fetch_unit
module tb_seq_fetch_unit;
  localparam int ACK_TIMEOUT = 16;
`ifdef FETCH_IFUN_CHECK_EN
  localparam logic IFCHK = 1'b1;
`else
  localparam logic IFCHK = 1'b0;
`endif
  logic Clk = 1'b0, Reset = 1'b1, start = 1'b0, mem_ack = 1'b0;
  logic mem_rd, busy, instr_valid, instr_invalid, imem_error;
  logic [63:0] PC = '0, mem_addr, valC, valP;
  logic [7:0] mem_rdata = '0;
  logic [3:0] icode, ifun, rA, rB;
  int vectors = 0, miscompares = 0, pulses = 0, cyc = 0, st = 0, nrd = 0, gap = 0, hold = -1, wt = 0, npl = 0;
  logic [63:0] rbase = '0, last = '0;
  logic [7:0] imem [logic [63:0]];
  typedef struct {
    logic [3:0] icode, ifun, ra, rb;
    logic [63:0] valc, valp;
    logic inv, err;
    int nreads, lat;
  } exp_t;
  exp_t sbq[$];
  exp_t me;

  seq_fetch_unit #(.ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .Clk(Clk), .Reset(Reset), .PC(PC), .start(start),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .instr_valid(instr_valid), .icode(icode), .ifun(ifun),
    .rA(rA), .rB(rB), .valC(valC), .valP(valP),
    .instr_invalid(instr_invalid), .imem_error(imem_error)
  );

  initial forever #5 Clk = ~Clk;
  initial forever begin
    @(posedge Clk);
    cyc++;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [63:0] a, input logic [79:0] b, input int n);
    for (int i = 0; i < n; i++) imem[a + 64'(i)] = b[79 - 8*i -: 8];
  endtask

  task automatic check_reset();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mem_rd", 64'(mem_rd), 64'd0);
    chk("rst_valid", 64'(instr_valid), 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_icode", 64'(icode), 64'd0);
    chk("rst_ifun", 64'(ifun), 64'd0);
    chk("rst_rA", 64'(rA), 64'hF);
    chk("rst_rB", 64'(rB), 64'hF);
    chk("rst_valC", valC, 64'd0);
    chk("rst_valP", valP, 64'd0);
    chk("rst_invalid", 64'(instr_invalid), 64'd0);
    chk("rst_imem_error", 64'(imem_error), 64'd0);
  endtask

  // push=1 records the expected result; push=0 is for fetches that get aborted
  task automatic launch(input logic [63:0] pc, input int g, input int h, input bit push, input exp_t e);
    @(negedge Clk);
    rbase = pc;
    nrd = 0;
    gap = g;
    hold = h;
    PC = pc;
    start = 1'b1;
    st = cyc;
    if (push) begin
      sbq.push_back(e);
      npl++;
    end
    @(negedge Clk);
    start = 1'b0;
    PC = {$urandom, $urandom};
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 400 && pulses < target; i++) @(negedge Clk);
    chk("valid_seen", 64'(pulses), 64'(target));
    repeat (2) @(negedge Clk);
    chk("single_pulse", 64'(pulses), 64'(target));
  endtask

  // Memory responder: ack after `gap` waiting cycles, never ack read index `hold`,
  // and throw spurious acks while mem_rd is low
  initial forever begin
    @(negedge Clk);
    mem_ack = 1'b0;
    if (mem_rd) begin
      if (wt > 0) chk("addr_stable", mem_addr, last);
      last = mem_addr;
      if (wt >= gap && nrd != hold) begin
        chk("rd_addr", mem_addr, rbase + 64'(nrd));
        mem_rdata = imem.exists(mem_addr) ? imem[mem_addr] : 8'h00;
        mem_ack = 1'b1;
        nrd++;
        wt = 0;
      end else wt++;
    end else begin
      wt = 0;
      mem_ack = cyc[0];
      mem_rdata = 8'($urandom);
    end
  end

  // Scoreboard: pop and compare on every instr_valid pulse
  initial forever begin
    @(negedge Clk);
    if (instr_valid) begin
      pulses++;
      chk("sb_nonempty", 64'(sbq.size() != 0), 64'd1);
      if (sbq.size() != 0) begin
        me = sbq.pop_front();
        chk("icode", 64'(icode), 64'(me.icode));
        chk("ifun", 64'(ifun), 64'(me.ifun));
        chk("rA", 64'(rA), 64'(me.ra));
        chk("rB", 64'(rB), 64'(me.rb));
        chk("valC", valC, me.valc);
        chk("valP", valP, me.valp);
        chk("instr_invalid", 64'(instr_invalid), 64'(me.inv));
        chk("imem_error", 64'(imem_error), 64'(me.err));
        chk("done_busy", 64'(busy), 64'd0);
        chk("done_mem_rd", 64'(mem_rd), 64'd0);
        chk("nreads", 64'(nrd), 64'(me.nreads));
        if (me.lat > 0) chk("latency", 64'(cyc - st + 1), 64'(me.lat));
      end
    end
  end

  initial begin
    exp_t e;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    check_reset();
    // irmovq, zero-wait: instr_valid in cycle 12 counting the start cycle as 1
    put(64'h100, 80'h30F20807060504030201, 10);
    e = '{4'h3, 4'h0, 4'hF, 4'h2, 64'h0102030405060708, 64'h10A, 1'b0, 1'b0, 10, 12};
    launch(64'h100, 0, -1, 1'b1, e);
    wait_done(npl);
    // jXX, ack every 3rd cycle
    put(64'h200, 80'h74000300000000000000, 9);
    e = '{4'h7, 4'h4, 4'hF, 4'hF, 64'h300, 64'h209, 1'b0, 1'b0, 9, 29};
    launch(64'h200, 2, -1, 1'b1, e);
    wait_done(npl);
    // ret, then an invalid icode
    put(64'h300, {8'h90, 72'h0}, 1);
    e = '{4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 64'h301, 1'b0, 1'b0, 1, 3};
    launch(64'h300, 0, -1, 1'b1, e);
    wait_done(npl);
    put(64'h400, {8'hC0, 72'h0}, 1);
    e = '{4'hC, 4'h0, 4'hF, 4'hF, 64'h0, 64'h401, 1'b1, 1'b0, 1, 3};
    launch(64'h400, 0, -1, 1'b1, e);
    wait_done(npl);
    // rmmovq with the first constant byte never acked: 16 waits then error
    put(64'h500, 80'h40120807060504030201, 10);
    e = '{4'h4, 4'h0, 4'h1, 4'h2, 64'h0, 64'h50A, 1'b0, 1'b1, 2, 20};
    launch(64'h500, 0, 2, 1'b1, e);
    wait_done(npl);
    // nop at the top of the address space: valP wraps to 0
    put(64'hFFFF_FFFF_FFFF_FFFF, {8'h10, 72'h0}, 1);
    e = '{4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0, 1'b0, 1, 3};
    launch(64'hFFFF_FFFF_FFFF_FFFF, 0, -1, 1'b1, e);
    wait_done(npl);
    // opq with ifun 7: illegal only when the ifun check is built in
    put(64'h600, {16'h6734, 64'h0}, 2);
    e = '{4'h6, 4'h7, 4'h3, 4'h4, 64'h0, 64'h602, IFCHK, 1'b0, 2, 4};
    launch(64'h600, 0, -1, 1'b1, e);
    wait_done(npl);
    // reset while in CONST aborts the fetch
    put(64'h700, 80'h30F20807060504030201, 10);
    e = '{4'h3, 4'h0, 4'hF, 4'h2, 64'h0102030405060708, 64'h70A, 1'b0, 1'b0, 10, 12};
    launch(64'h700, 0, -1, 1'b0, e);
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check_reset();
    repeat (15) @(negedge Clk);
    chk("no_valid_after_abort", 64'(pulses), 64'(npl));
    launch(64'h700, 0, -1, 1'b1, e);
    wait_done(npl);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/seq_fetch_unit.md
Name: seq_fetch_unit

Overview:
- Fetch stage of the sequential Y86-64 core. Sits directly downstream of the PC update stage and consumes its PC output.
- On a start pulse it reads the instruction at PC one byte at a time over a byte-wide instruction-memory handshake.
- It decodes the byte count from icode and assembles icode/ifun/rA/rB/valC/valP for the decode stage.
- The result is signalled with a one-cycle instr_valid pulse; the field outputs then hold.

Parameters:
- ACK_TIMEOUT, 16: maximum cycles mem_rd may wait for mem_ack before imem_error is raised (1..255).

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- PC  input  64  instruction address, sampled on the start cycle.
- start  input  1  request a fetch; ignored while busy=1.
- mem_addr  output  64  byte address presented to instruction memory.
- mem_rd  output  1  read request; held high with mem_addr stable until mem_ack.
- mem_rdata  input  8  read byte; valid in the cycle mem_ack=1.
- mem_ack  input  1  byte accepted/returned.
- busy  output  1  fetch in progress.
- instr_valid  output  1  one-cycle pulse: fields below are complete.
- icode  output  4  instruction code (byte0[7:4]).
- ifun  output  4  function code (byte0[3:0]).
- rA  output  4  register byte[7:4]; 4'hF if the instruction has no register byte.
- rB  output  4  register byte[3:0]; 4'hF if the instruction has no register byte.
- valC  output  64  little-endian constant; 0 if the instruction has no constant.
- valP  output  64  PC + instruction length, modulo 2^64.
- instr_invalid  output  1  icode > 4'hB (plus ifun check, see Optional Feature).
- imem_error  output  1  memory ack timeout occurred during this fetch.

Behaviour:
- Reset values: all outputs 0, except rA = rB = 4'hF. State is IDLE.
- Reset mid-fetch aborts at the next edge: mem_rd = 0, no instr_valid.
- FSM states: IDLE, BYTE0, REGS, CONST, DONE.
- IDLE:
  - start=1 latches PC into base and fetch address, clears the error flags, sets busy=1, and moves to BYTE0.
  - mem_rd=1 is asserted from the next cycle.
- Byte handshake:
  - A byte is consumed only in a cycle with mem_rd=1 and mem_ack=1.
  - mem_addr then increments by 1 (64-bit wrap).
  - mem_ack while mem_rd=0 is ignored.
- BYTE0 (on ack):
  - Latch icode and ifun.
  - Next state by icode:
    - 0, 1, 9 (1 byte): go to DONE.
    - 2, 6, A, B (2 bytes): go to REGS.
    - 3, 4, 5 (10 bytes): go to REGS, then CONST for 8 bytes.
    - 7, 8 (9 bytes): go to CONST for 8 bytes.
    - C–F: set instr_invalid, length 1, go to DONE.
- REGS (on ack): latch rA/rB, then go to CONST or DONE.
- CONST:
  - The k-th acked byte (k = 0..7) is written to valC[8k+7:8k].
  - A 3-bit counter tracks k; after k = 7, go to DONE.
- Timeout:
  - A wait counter resets on each ack and counts cycles with mem_rd=1 and mem_ack=0.
  - When it reaches ACK_TIMEOUT: set imem_error, drop mem_rd, go to DONE.
  - Fields already fetched are kept; unfetched fields keep their defaults.
- DONE:
  - instr_valid=1 for exactly one cycle.
  - valP = base + length, where length is the decoded length (1 for invalid or error-at-byte0).
  - busy drops to 0 in the same cycle; next state is IDLE.
- Outputs hold until the next accepted start.
- start asserted in the DONE cycle is ignored. Earliest accepted start is in the IDLE cycle after DONE.
- Latency with zero-wait memory (ack in the first mem_rd cycle): length + 2 cycles from start to instr_valid.

Optional Feature:
- Macro FETCH_IFUN_CHECK_EN.
- Defined: instr_invalid is also set when the ifun code is illegal for the icode:
  - icode 2 or 7: ifun > 6 is illegal.
  - icode 6: ifun > 3 is illegal.
  - all other valid icodes: ifun != 0 is illegal.
  - The fetch still completes the full decoded length.
- Not defined: only icode > 4'hB sets instr_invalid; ifun is passed through unchecked.

Test Plan:
- irmovq, PC=0x100:
  - Stimulus: bytes 30 F2 08 07 06 05 04 03 02 01, zero-wait ack.
  - Response: 10 reads at 0x100..0x109; icode=3, ifun=0, rA=F, rB=2, valC=0x0102030405060708, valP=0x10A; instr_valid 12 cycles after start.
- jXX, PC=0x200:
  - Stimulus: bytes 74 00 03 00 00 00 00 00 00, ack every 3rd cycle.
  - Response: icode=7, ifun=4, rA=rB=F, valC=0x300, valP=0x209; mem_addr stable while waiting; exactly 9 reads.
- ret then invalid:
  - Stimulus: ret (0x90) at 0x300; then 0xC0 at 0x400.
  - Response: ret gives valP=0x301, one read, instr_invalid=0. Then 0xC0 gives instr_invalid=1, valP=0x401, one read.
- Timeout, ACK_TIMEOUT=16:
  - Stimulus: rmmovq at 0x500; ack withheld on byte 3.
  - Response: after 16 waiting cycles, imem_error=1, mem_rd=0, one instr_valid pulse; rA/rB from the register byte retained; valC=0.
- Wrap-around:
  - Stimulus: nop (0x10) at PC=0xFFFFFFFFFFFFFFFF.
  - Response: valP=0.
- Reset mid-fetch:
  - Stimulus: Reset asserted during CONST.
  - Response: next cycle busy=0, mem_rd=0, outputs at reset values, no instr_valid.
  - Follow-up: a subsequent start fetches normally.
- FETCH_IFUN_CHECK_EN:
  - Stimulus: byte 0x67.
  - Response: instr_invalid=1 when the macro is defined, 0 when it is not; valP=PC+2 in both cases.
